router_1xn: RTL

Parametrised 1-to-N packet router, the successor to the fixed 1x3 router top. It accepts byte-serial packets (header, payload, parity) on a single input port, checks parity and length, and buffers each packet whole in the per-destination FIFO selected by the header address. Over the 1x3 router it adds:
- configurable data width, channel count and FIFO depth;
- invalid-address dropping;
- length checking;
- per-channel stall-timeout flush.

---
 rtl/router_1xn.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/router_1xn.sv
// router_1xn: 1-to-N byte-serial packet router with per-channel
// store FIFOs, parity/length/address checking and stall flush.
module router_1xn #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 2,
  parameter int NUM_CH     = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pkt_valid,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     busy,
  output logic                     err,
  input  logic [NUM_CH-1:0]        read_en,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        valid_out,
  output logic [NUM_CH-1:0]        soft_rst
);
  localparam int LEN_W = DATA_W - ADDR_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int SLOTS = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DROP} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [LEN_W-1:0]  len_q, len_nx;
  logic [LEN_W-1:0]  cnt_q, cnt_nx;
  logic [DATA_W-1:0] par_q, par_nx;
  logic [DATA_W-1:0] rx_par_q, rx_par_nx;
  logic              err_q, err_nx;

  logic [ADDR_W-1:0] hdr_addr;
  logic [LEN_W-1:0]  hdr_len;
  logic              hdr_ok;

  logic [NUM_CH-1:0] full, empty, flush, pop, wr_en;
  logic [SLOTS-1:0]  full_slot, flush_slot, wr_slot;

  assign hdr_addr = data_in[ADDR_W-1:0];
  assign hdr_len  = data_in[DATA_W-1:ADDR_W];
  assign hdr_ok   = (32'(hdr_addr) < 32'(NUM_CH));
  assign err      = err_q;
  assign wr_en    = wr_slot[NUM_CH-1:0];

  // Widen per-channel flags to the full address space.
  always_comb begin
    full_slot  = '0;
    flush_slot = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      full_slot[k]  = full[k];
      flush_slot[k] = flush[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      par_q    <= '0;
      rx_par_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      addr_q   <= addr_nx;
      len_q    <= len_nx;
      cnt_q    <= cnt_nx;
      par_q    <= par_nx;
      rx_par_q <= rx_par_nx;
      err_q    <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    addr_nx   = addr_q;
    len_nx    = len_q;
    cnt_nx    = cnt_q;
    par_nx    = par_q;
    rx_par_nx = rx_par_q;
    err_nx    = err_q;
    busy      = 1'b0;
    wr_slot   = '0;
    unique case (state)
      IDLE: begin
        if (pkt_valid) begin
          if (!hdr_ok) begin
            err_nx   = 1'b1;
            state_nx = DROP;
          end else if (full_slot[hdr_addr]) begin
            busy = 1'b1;
          end else begin
            wr_slot[hdr_addr] = 1'b1;
            addr_nx  = hdr_addr;
            len_nx   = hdr_len;
            par_nx   = data_in;
            cnt_nx   = '0;
            err_nx   = 1'b0;
            state_nx = LOAD;
            // A header landing on the flush edge is lost with it.
            if (flush_slot[hdr_addr]) begin
              err_nx   = 1'b1;
              state_nx = DROP;
            end
          end
        end
      end
      LOAD: begin
        busy = full_slot[addr_q];
        if (flush_slot[addr_q]) begin
          err_nx   = 1'b1;
          state_nx = DROP;
        end else if (!full_slot[addr_q]) begin
          wr_slot[addr_q] = 1'b1;
          if (pkt_valid) begin
            par_nx = par_q ^ data_in;
            if (cnt_q != '1) cnt_nx = cnt_q + 1'b1;
          end else begin
            rx_par_nx = data_in;
            state_nx  = CHECK;
          end
        end
      end
      CHECK: begin
        busy     = 1'b1;
        err_nx   = (par_q != rx_par_q) || (cnt_q != len_q);
        state_nx = IDLE;
      end
      DROP: begin
        if (!pkt_valid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]    wp, rp;
    logic [TO_W-1:0]   stall;
    logic              srst_q;
    logic              stalled;

    assign empty[k] = (wp == rp);
    assign full[k]  = (wp[PTR_W] != rp[PTR_W]) &&
                      (wp[PTR_W-1:0] == rp[PTR_W-1:0]);
    assign pop[k]   = read_en[k] & ~empty[k];
    assign stalled  = ~empty[k] & ~read_en[k];
    assign flush[k] = stalled & (stall == TO_W'(TIMEOUT - 1));

    assign valid_out[k] = ~empty[k];
    assign soft_rst[k]  = srst_q;
    assign data_out[k*DATA_W +: DATA_W] =
      empty[k] ? '0 : mem[rp[PTR_W-1:0]];

    always_ff @(posedge clk) begin
      if (rst) begin
        wp     <= '0;
        rp     <= '0;
        stall  <= '0;
        srst_q <= 1'b0;
      end else begin
        srst_q <= flush[k];
        if (flush[k]) begin
          wp    <= '0;
          rp    <= '0;
          stall <= '0;
        end else begin
          if (wr_en[k]) wp <= wp + 1'b1;
          if (pop[k])   rp <= rp + 1'b1;
          stall <= stalled ? stall + 1'b1 : '0;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (wr_en[k] && !flush[k]) mem[wp[PTR_W-1:0]] <= data_in;
    end
  end

endmodule
